// File: rtl/mutative_miss_handler.sv
// mutative_miss_handler: latches PLRU victim on a miss, writes back dirty victim, fetches and fills the line
module mutative_miss_handler #(
  parameter int WAYS         = 4,
  parameter int WAY_IDX_BITS = 2,
  parameter int SET_IDX_BITS = 4,
  parameter int OFFSET_BITS  = 5,
  parameter int TAG_BITS     = 23,
  parameter int LINE_BITS    = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    miss_req,
  input  logic [31:0]             miss_addr,
  input  logic [WAY_IDX_BITS-1:0] evict_way,
  input  logic [WAYS-1:0]         evict_we,
  input  logic                    victim_valid,
  input  logic                    victim_dirty,
  input  logic [TAG_BITS-1:0]     victim_tag,
  input  logic [LINE_BITS-1:0]    victim_data,
  output logic [31:0]             mem_addr,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [LINE_BITS-1:0]    mem_wdata,
  input  logic [LINE_BITS-1:0]    mem_rdata,
  input  logic                    mem_resp,
  output logic [WAYS-1:0]         fill_we,
  output logic [SET_IDX_BITS-1:0] fill_set,
  output logic [TAG_BITS-1:0]     fill_tag,
  output logic [LINE_BITS-1:0]    fill_data,
  output logic                    fill_done,
  output logic                    plru_touch,
  output logic [WAY_IDX_BITS-1:0] plru_way,
  output logic                    busy,
  output logic                    proto_err
);
  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, FILL} state_t;
  state_t state_q, state_d;
  logic [TAG_BITS-1:0] tag_q, tag_d, vtag_q, vtag_d, fill_tag_q, fill_tag_d;
  logic [SET_IDX_BITS-1:0] set_q, set_d, fill_set_q, fill_set_d;
  logic [WAY_IDX_BITS-1:0] way_q, way_d, plru_way_q, plru_way_d;
  logic [LINE_BITS-1:0] vdata_q, vdata_d, data_q, data_d;
  logic [LINE_BITS-1:0] mem_wdata_q, mem_wdata_d, fill_data_q, fill_data_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [WAYS-1:0] fill_we_q, fill_we_d, evict_dec;
  logic mem_read_q, mem_read_d, mem_write_q, mem_write_d, fill_done_q, fill_done_d;
  logic plru_touch_q, plru_touch_d, busy_q, busy_d, perr_q, perr_d;
  logic unused_offset;
  assign unused_offset = &{1'b0, miss_addr[OFFSET_BITS-1:0]};
  assign mem_addr   = mem_addr_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_wdata  = mem_wdata_q;
  assign fill_we    = fill_we_q;
  assign fill_set   = fill_set_q;
  assign fill_tag   = fill_tag_q;
  assign fill_data  = fill_data_q;
  assign fill_done  = fill_done_q;
  assign plru_touch = plru_touch_q;
  assign plru_way   = plru_way_q;
  assign busy       = busy_q;
  assign proto_err  = perr_q;
  // next-state, miss capture, and registered outputs derived from the state being entered
  always_comb begin
    evict_dec = WAYS'(1) << evict_way;
    state_d = state_q;
    tag_d = tag_q;
    set_d = set_q;
    way_d = way_q;
    vtag_d = vtag_q;
    vdata_d = vdata_q;
    data_d = data_q;
    perr_d = perr_q;
    if (state_q == IDLE && miss_req) begin
      tag_d = miss_addr[31 -: TAG_BITS];
      set_d = miss_addr[OFFSET_BITS +: SET_IDX_BITS];
      way_d = evict_way;
      vtag_d = victim_tag;
      vdata_d = victim_data;
      perr_d = perr_q | (evict_we != evict_dec);
      state_d = (victim_valid && victim_dirty) ? WRITEBACK : FETCH;
    end
    if (state_q == WRITEBACK && mem_resp) state_d = FETCH;
    if (state_q == FETCH && mem_resp) begin
      data_d = mem_rdata;
      state_d = FILL;
    end
    if (state_q == FILL) state_d = IDLE;
    mem_write_d = state_d == WRITEBACK;
    mem_read_d = state_d == FETCH;
    mem_addr_d = mem_write_d ? {vtag_d, set_d, {OFFSET_BITS{1'b0}}} :
                 mem_read_d ? {tag_d, set_d, {OFFSET_BITS{1'b0}}} : '0;
    mem_wdata_d = mem_write_d ? vdata_d : '0;
    fill_done_d = state_d == FILL;
    fill_we_d = fill_done_d ? WAYS'(1) << way_d : '0;
    fill_set_d = fill_done_d ? set_d : '0;
    fill_tag_d = fill_done_d ? tag_d : '0;
    fill_data_d = fill_done_d ? data_d : '0;
    plru_touch_d = fill_done_d;
    plru_way_d = fill_done_d ? way_d : '0;
    busy_d = state_d != IDLE;
  end
  // state, latch and output registers; async reset abandons any in-flight request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tag_q <= '0;
      set_q <= '0;
      way_q <= '0;
      vtag_q <= '0;
      vdata_q <= '0;
      data_q <= '0;
      perr_q <= 1'b0;
      mem_addr_q <= '0;
      mem_read_q <= 1'b0;
      mem_write_q <= 1'b0;
      mem_wdata_q <= '0;
      fill_we_q <= '0;
      fill_set_q <= '0;
      fill_tag_q <= '0;
      fill_data_q <= '0;
      fill_done_q <= 1'b0;
      plru_touch_q <= 1'b0;
      plru_way_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tag_q <= tag_d;
      set_q <= set_d;
      way_q <= way_d;
      vtag_q <= vtag_d;
      vdata_q <= vdata_d;
      data_q <= data_d;
      perr_q <= perr_d;
      mem_addr_q <= mem_addr_d;
      mem_read_q <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_wdata_q <= mem_wdata_d;
      fill_we_q <= fill_we_d;
      fill_set_q <= fill_set_d;
      fill_tag_q <= fill_tag_d;
      fill_data_q <= fill_data_d;
      fill_done_q <= fill_done_d;
      plru_touch_q <= plru_touch_d;
      plru_way_q <= plru_way_d;
      busy_q <= busy_d;
    end
  end
endmodule

// File: tb/tb_mutative_miss_handler.sv
// tb_mutative_miss_handler: scenario tasks plus randomized misses checked against a transaction-level model
module tb_mutative_miss_handler;
  logic clk, rst, miss_req, victim_valid, victim_dirty, mem_resp;
  logic [31:0] miss_addr, mem_addr;
  logic [1:0] evict_way, plru_way;
  logic [3:0] evict_we, fill_we, fill_set;
  logic [22:0] victim_tag, fill_tag;
  logic [255:0] victim_data, mem_wdata, mem_rdata, fill_data;
  logic mem_read, mem_write, fill_done, plru_touch, busy, proto_err;
  int n_cmp = 0, n_err = 0;
  bit exp_perr = 0;

  mutative_miss_handler dut (
    .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
    .evict_way(evict_way), .evict_we(evict_we), .victim_valid(victim_valid),
    .victim_dirty(victim_dirty), .victim_tag(victim_tag), .victim_data(victim_data),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .fill_we(fill_we), .fill_set(fill_set),
    .fill_tag(fill_tag), .fill_data(fill_data), .fill_done(fill_done),
    .plru_touch(plru_touch), .plru_way(plru_way), .busy(busy), .proto_err(proto_err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One complete miss transaction; expected bus activity comes from address arithmetic
  task automatic run_miss(input logic [31:0] addr, input logic [1:0] way, input logic [3:0] we,
                          input bit v, input bit d, input logic [22:0] vt, input logic [255:0] vd,
                          input logic [255:0] rd, input int wbd, input int fd, input bit noise,
                          input string nm);
    bit wb;
    logic [31:0] wa, fa;
    logic [3:0] fwe;
    logic [22:0] et;
    logic [3:0] es;
    wb = v && d;
    wa = (32'(vt) << 9) | (addr & 32'h0000_01E0);
    fa = addr & 32'hFFFF_FFE0;
    fwe = 4'(1 << way);
    et = 23'(addr >> 9);
    es = 4'((addr >> 5) % 16);
    if (we != fwe) exp_perr = 1;
    miss_addr = addr; evict_way = way; evict_we = we; victim_valid = v; victim_dirty = d;
    victim_tag = vt; victim_data = vd; miss_req = 1;
    @(posedge clk); #1;
    miss_req = 0; victim_tag = ~vt; victim_data = ~vd; evict_way = ~way; evict_we = ~we;
    if (wb)
      for (int i = 0; i <= wbd; i++) begin
        n_cmp++;
        if ({mem_write, mem_read, busy, mem_addr, mem_wdata} !== {3'b101, wa, vd}) begin
          n_err++;
          $display("FAIL %s writeback[%0d]: got w=%b r=%b busy=%b addr=%h wdata=%h, want w=1 r=0 busy=1 addr=%h wdata=%h",
                   nm, i, mem_write, mem_read, busy, mem_addr, mem_wdata, wa, vd);
        end
        if (i == wbd) mem_resp = 1;
        @(posedge clk); #1;
        mem_resp = 0;
      end
    for (int i = 0; i <= fd; i++) begin
      n_cmp++;
      if ({mem_write, mem_read, busy, mem_addr, mem_wdata} !== {3'b011, fa, 256'b0}) begin
        n_err++;
        $display("FAIL %s fetch[%0d]: got w=%b r=%b busy=%b addr=%h wdata=%h, want w=0 r=1 busy=1 addr=%h wdata=0",
                 nm, i, mem_write, mem_read, busy, mem_addr, mem_wdata, fa);
      end
      if (noise) begin
        miss_req = 1; miss_addr = $urandom; evict_way = 2'($urandom); evict_we = 4'($urandom);
        victim_valid = 1; victim_dirty = 1;
      end
      if (i == fd) begin mem_resp = 1; mem_rdata = rd; end
      @(posedge clk); #1;
      mem_resp = 0; mem_rdata = ~rd;
    end
    n_cmp++;
    if ({fill_we, fill_set, fill_tag, fill_data, fill_done, plru_touch, plru_way, mem_read, mem_write, busy, mem_addr}
        !== {fwe, es, et, rd, 1'b1, 1'b1, way, 1'b0, 1'b0, 1'b1, 32'b0}) begin
      n_err++;
      $display("FAIL %s fill: got we=%b set=%h tag=%h data=%h done=%b touch=%b way=%0d r=%b w=%b busy=%b addr=%h, want we=%b set=%h tag=%h data=%h done=1 touch=1 way=%0d r=0 w=0 busy=1 addr=0",
               nm, fill_we, fill_set, fill_tag, fill_data, fill_done, plru_touch, plru_way, mem_read, mem_write, busy, mem_addr,
               fwe, es, et, rd, way);
    end
    n_cmp++;
    if (proto_err !== exp_perr) begin
      n_err++;
      $display("FAIL %s proto_err: got %b want %b", nm, proto_err, exp_perr);
    end
    @(posedge clk); #1;
    miss_req = 0;
    n_cmp++;
    if ({busy, fill_done, fill_we, plru_touch, mem_read, mem_write} !== 9'b0) begin
      n_err++;
      $display("FAIL %s idle_after_fill: got busy=%b done=%b we=%b touch=%b r=%b w=%b, want all 0",
               nm, busy, fill_done, fill_we, plru_touch, mem_read, mem_write);
    end
  endtask

  task automatic test_reset();
    rst = 1; miss_req = 0; miss_addr = 0; evict_way = 0; evict_we = 0; victim_valid = 0;
    victim_dirty = 0; victim_tag = 0; victim_data = 0; mem_rdata = 0; mem_resp = 0;
    #12;
    n_cmp++;
    if ({mem_addr, mem_read, mem_write, mem_wdata, fill_we, fill_set, fill_tag, fill_data, fill_done,
         plru_touch, plru_way, busy, proto_err} !== '0) begin
      n_err++;
      $display("FAIL reset: outputs not zero (addr=%h r=%b w=%b we=%b done=%b busy=%b perr=%b)",
               mem_addr, mem_read, mem_write, fill_we, fill_done, busy, proto_err);
    end
    @(negedge clk); rst = 0; exp_perr = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_clean_miss();
    run_miss(32'h0000_1240, 2'd2, 4'b0100, 0, 0, 23'h0, rand_line(), {32{8'hA5}}, 0, 3, 0, "clean_miss");
  endtask

  task automatic test_dirty_miss();
    run_miss(32'h0000_0420, 2'd1, 4'b0010, 1, 1, 23'h7, rand_line(), rand_line(), 2, 1, 0, "dirty_miss");
    run_miss(32'h0000_0420, 2'd0, 4'b0001, 0, 1, 23'h7, rand_line(), rand_line(), 0, 0, 0, "invalid_dirty");
  endtask

  task automatic test_immediate_resp();
    run_miss(32'hDEAD_BEE0, 2'd3, 4'b1000, 0, 0, 23'h0, rand_line(), rand_line(), 0, 0, 0, "immediate_resp");
    run_miss(32'h1234_5660, 2'd0, 4'b0001, 1, 1, 23'h55, rand_line(), rand_line(), 0, 0, 0, "immediate_wb");
  endtask

  task automatic test_ignored_miss();
    run_miss(32'h0ABC_0180, 2'd1, 4'b0010, 1, 1, 23'h3A, rand_line(), rand_line(), 1, 2, 1, "ignored_miss");
  endtask

  task automatic test_proto_err();
    run_miss(32'h0000_0060, 2'd3, 4'b0001, 0, 0, 23'h0, rand_line(), rand_line(), 0, 1, 0, "proto_err");
    run_miss(32'h0000_00A0, 2'd0, 4'b0001, 0, 0, 23'h0, rand_line(), rand_line(), 0, 0, 0, "proto_sticky");
  endtask

  task automatic test_async_reset();
    miss_addr = 32'h0000_0840; evict_way = 1; evict_we = 4'b0010; victim_valid = 1; victim_dirty = 1;
    victim_tag = 23'h11; victim_data = rand_line(); miss_req = 1;
    @(posedge clk); #1;
    miss_req = 0;
    n_cmp++;
    if (mem_write !== 1'b1) begin
      n_err++;
      $display("FAIL async_reset pre: mem_write got %b want 1", mem_write);
    end
    #2; rst = 1; #1;
    n_cmp++;
    if ({mem_write, mem_read, busy, mem_addr, proto_err} !== '0) begin
      n_err++;
      $display("FAIL async_reset drop: got w=%b r=%b busy=%b addr=%h perr=%b want all 0",
               mem_write, mem_read, busy, mem_addr, proto_err);
    end
    exp_perr = 0; mem_resp = 1;
    @(posedge clk); #1;
    mem_resp = 0;
    n_cmp++;
    if ({fill_we, fill_done, busy} !== 6'b0) begin
      n_err++;
      $display("FAIL async_reset hold: got we=%b done=%b busy=%b want 0", fill_we, fill_done, busy);
    end
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    run_miss(32'h0000_1240, 2'd2, 4'b0100, 0, 0, 23'h0, rand_line(), rand_line(), 0, 1, 0, "after_reset");
  endtask

  task automatic test_random();
    for (int k = 0; k < 25; k++) begin
      logic [1:0] w;
      logic [3:0] we;
      w = 2'($urandom);
      we = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(1 << w);
      mem_resp = 1;
      @(posedge clk); #1;
      mem_resp = 0;
      n_cmp++;
      if (busy !== 1'b0) begin
        n_err++;
        $display("FAIL idle_resp[%0d]: busy got %b want 0", k, busy);
      end
      run_miss($urandom, w, we, 1'($urandom), 1'($urandom), 23'($urandom), rand_line(), rand_line(),
               $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_immediate_resp();
    test_ignored_miss();
    test_proto_err();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
